// File: rtl/sm_matrix_sum_pkg.sv
// Shared geometry, state encoding and word type for the matrix-sum scanner.
package sm_matrix_sum_pkg;
  localparam int DATA_W = 32;
  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int ADDR_W = 4;
  localparam int ROW_W  = $clog2(ROWS);
  localparam int COL_W  = $clog2(COLS);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROWS*COLS-1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef logic [DATA_W-1:0] word_t;
endpackage

// File: rtl/sm_matrix_sum_if.sv
// Second (debug) read port of the matrix RAM: address out, registered data back.
interface sm_matrix_sum_if;
  import sm_matrix_sum_pkg::*;

  logic [ADDR_W-1:0] mAddr;
  word_t             mRData;

  modport master (output mAddr, input mRData);
  modport slave  (input mAddr, output mRData);
endinterface

// File: rtl/sm_matrix_acc.sv
// Row and total accumulators with sticky carry-out detection.
module sm_matrix_acc
  import sm_matrix_sum_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         en,
  input  logic [ROW_W-1:0]             rowIdx,
  input  word_t                        data,
  output logic [ROWS-1:0][DATA_W-1:0]  rowAcc,
  output word_t                        totAcc,
  output logic                         ovf
);
  logic [DATA_W:0] rowAdd;
  logic [DATA_W:0] totAdd;

  // One extra bit captures the carry-out of each modular add.
  assign rowAdd = {1'b0, rowAcc[rowIdx]} + {1'b0, data};
  assign totAdd = {1'b0, totAcc} + {1'b0, data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rowAcc <= '0;
      totAcc <= '0;
      ovf    <= 1'b0;
    end else if (clr) begin
      rowAcc <= '0;
      totAcc <= '0;
      ovf    <= 1'b0;
    end else if (en) begin
      rowAcc[rowIdx] <= rowAdd[DATA_W-1:0];
      totAcc         <= totAdd[DATA_W-1:0];
      if (rowAdd[DATA_W] || totAdd[DATA_W]) ovf <= 1'b1;
    end
  end
endmodule

// File: rtl/sm_matrix_sum.sv
// Scans the 4x4 matrix RAM on start and commits row sums, grand total and overflow.
//  state | meaning
//  IDLE  | waiting for start; address 0 presented so word 0 is read on the start edge
//  READ  | issuing addresses 1..15, accumulating returned words
//  DRAIN | last word absorbed; commit results and pulse done
module sm_matrix_sum
  import sm_matrix_sum_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  sm_matrix_sum_if.master        ramPort,
  output logic                   busy,
  output logic                   done,
  output logic                   ovf,
  input  logic [ROW_W-1:0]       rowSel,
  output word_t                  rowSum,
  output word_t                  total
);
  state_t                       state, stateNext;
  logic [ADDR_W-1:0]            cnt;
  logic                         issue, clrAcc, commit;
  logic                         vld;
  logic [ROW_W-1:0]             rowD;
  logic [ROWS-1:0][DATA_W-1:0]  rowAcc, rowRes;
  word_t                        totAcc, totRes;
  logic                         ovfAcc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    issue     = 1'b0;
    clrAcc    = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          stateNext = READ;
          issue     = 1'b1;
          clrAcc    = 1'b1;
        end
      end
      READ: begin
        if (cnt == LAST_ADDR) stateNext = DRAIN;
        else                  issue     = 1'b1;
      end
      DRAIN: begin
        stateNext = IDLE;
        commit    = 1'b1;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Address is one ahead of cnt so the registered RAM returns word k in time to be added at edge k+1.
  assign ramPort.mAddr = (state == READ && cnt != LAST_ADDR) ? cnt + 1'b1 : '0;
  assign busy          = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      vld  <= 1'b0;
      rowD <= '0;
      done <= 1'b0;
    end else begin
      if (clrAcc || commit) cnt <= '0;
      else if (issue)       cnt <= cnt + 1'b1;
      vld  <= issue;
      rowD <= ramPort.mAddr[ADDR_W-1:COL_W];
      done <= commit;
    end
  end

  sm_matrix_acc uAcc (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (clrAcc),
    .en     (vld),
    .rowIdx (rowD),
    .data   (ramPort.mRData),
    .rowAcc (rowAcc),
    .totAcc (totAcc),
    .ovf    (ovfAcc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rowRes <= '0;
      totRes <= '0;
      ovf    <= 1'b0;
    end else if (commit) begin
      rowRes <= rowAcc;
      totRes <= totAcc;
      ovf    <= ovfAcc;
    end
  end

  assign rowSum = rowRes[rowSel];
  assign total  = totRes;
endmodule

// File: tb/tb_sm_matrix_sum.sv
// Bench for sm_matrix_sum: RAM model with registered read, scan scenarios and random contents.
module tb_sm_matrix_sum;
  import sm_matrix_sum_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        busy, done, ovf;
  logic [1:0]  rowSel;
  word_t       rowSum, total;
  logic [31:0] ram [16];

  int total_cnt = 0;
  int bad_cnt   = 0;

  logic [31:0] expRow [4];
  logic [31:0] expTot;
  logic        expOvf;

  sm_matrix_sum_if ramIf ();

  sm_matrix_sum dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .ramPort (ramIf.master),
    .busy    (busy),
    .done    (done),
    .ovf     (ovf),
    .rowSel  (rowSel),
    .rowSum  (rowSum),
    .total   (total)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) ramIf.mRData <= ram[ramIf.mAddr];

  // Reference: row-major 4x4 sums with modular wrap and carry detection.
  task automatic model();
    longint s;
    for (int r = 0; r < 4; r++) expRow[r] = 32'd0;
    expTot = 32'd0;
    expOvf = 1'b0;
    for (int k = 0; k < 16; k++) begin
      s = longint'(expRow[k/4]) + longint'(ram[k]);
      if (s >= 64'h1_0000_0000) expOvf = 1'b1;
      expRow[k/4] = s[31:0];
      s = longint'(expTot) + longint'(ram[k]);
      if (s >= 64'h1_0000_0000) expOvf = 1'b1;
      expTot = s[31:0];
    end
  endtask

  // Pulse start, return edges from the start edge to done (-1 if never seen).
  task automatic run_scan(output int lat);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    lat = -1;
    for (int e = 1; e <= 60; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (done && lat < 0) lat = e;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; rowSel = 2'd0;
    for (int k = 0; k < 16; k++) ram[k] = 32'd0;
    #12;
    total_cnt++; if (busy !== 1'b0) begin bad_cnt++; $display("FAIL reset_busy got=%0b want=0", busy); end
    total_cnt++; if (done !== 1'b0) begin bad_cnt++; $display("FAIL reset_done got=%0b want=0", done); end
    total_cnt++; if (ovf !== 1'b0) begin bad_cnt++; $display("FAIL reset_ovf got=%0b want=0", ovf); end
    total_cnt++; if (ramIf.mAddr !== 4'd0) begin bad_cnt++; $display("FAIL reset_maddr got=%0d want=0", ramIf.mAddr); end
    total_cnt++; if (total !== 32'd0) begin bad_cnt++; $display("FAIL reset_total got=%h want=0", total); end
    total_cnt++; if (rowSum !== 32'd0) begin bad_cnt++; $display("FAIL reset_rowsum got=%h want=0", rowSum); end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_basic(input string tag);
    int lat;
    for (int k = 0; k < 16; k++) ram[k] = 32'(k + 1);
    model();
    run_scan(lat);
    total_cnt++; if (lat !== 17) begin bad_cnt++; $display("FAIL %s_latency got=%0d want=17", tag, lat); end
    for (int r = 0; r < 4; r++) begin
      rowSel = r[1:0]; #1;
      total_cnt++; if (rowSum !== expRow[r]) begin bad_cnt++; $display("FAIL %s_row%0d got=%0d want=%0d", tag, r, rowSum, expRow[r]); end
    end
    total_cnt++; if (total !== expTot) begin bad_cnt++; $display("FAIL %s_total got=%0d want=%0d", tag, total, expTot); end
    total_cnt++; if (ovf !== expOvf) begin bad_cnt++; $display("FAIL %s_ovf got=%0b want=%0b", tag, ovf, expOvf); end
  endtask

  task automatic test_saturate();
    int lat;
    for (int k = 0; k < 16; k++) ram[k] = 32'hFFFF_FFFF;
    model();
    run_scan(lat);
    for (int r = 0; r < 4; r++) begin
      rowSel = r[1:0]; #1;
      total_cnt++; if (rowSum !== expRow[r]) begin bad_cnt++; $display("FAIL ones_row%0d got=%h want=%h", r, rowSum, expRow[r]); end
    end
    total_cnt++; if (total !== expTot) begin bad_cnt++; $display("FAIL ones_total got=%h want=%h", total, expTot); end
    total_cnt++; if (ovf !== 1'b1) begin bad_cnt++; $display("FAIL ones_ovf got=%0b want=1", ovf); end
    for (int k = 0; k < 16; k++) ram[k] = 32'd0;
    run_scan(lat);
    total_cnt++; if (ovf !== 1'b0) begin bad_cnt++; $display("FAIL zeros_ovf got=%0b want=0", ovf); end
    total_cnt++; if (total !== 32'd0) begin bad_cnt++; $display("FAIL zeros_total got=%h want=0", total); end
  endtask

  task automatic test_start_while_busy();
    int dones = 0;
    int doneEdge = -1;
    for (int k = 0; k < 16; k++) ram[k] = 32'(k + 1);
    model();
    @(negedge clk) start = 1'b1;
    for (int e = 0; e < 50; e++) begin
      @(posedge clk);
      @(negedge clk);
      start = (e == 2 || e == 9);
      if (e < 17) begin
        total_cnt++; if (busy !== 1'b1) begin bad_cnt++; $display("FAIL busy_hold edge=%0d got=%0b want=1", e, busy); end
      end
      if (done) begin dones++; doneEdge = e; end
    end
    total_cnt++; if (dones !== 1) begin bad_cnt++; $display("FAIL restart_dones got=%0d want=1", dones); end
    total_cnt++; if (doneEdge !== 17) begin bad_cnt++; $display("FAIL restart_done_edge got=%0d want=17", doneEdge); end
    total_cnt++; if (total !== expTot) begin bad_cnt++; $display("FAIL restart_total got=%0d want=%0d", total, expTot); end
  endtask

  task automatic test_back_to_back();
    int doneEdges [$];
    for (int k = 0; k < 16; k++) ram[k] = 32'(3 * k + 7);
    model();
    @(negedge clk) start = 1'b1;
    for (int e = 0; e < 60; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (e == 39) start = 1'b0;
      if (done) doneEdges.push_back(e);
      if (e > 17 && e < 35) begin
        total_cnt++; if (total !== expTot) begin bad_cnt++; $display("FAIL b2b_stable edge=%0d got=%0d want=%0d", e, total, expTot); end
      end
    end
    total_cnt++; if (doneEdges.size() !== 3) begin bad_cnt++; $display("FAIL b2b_count got=%0d want=3", doneEdges.size()); end
    if (doneEdges.size() >= 2) begin
      total_cnt++; if (doneEdges[0] !== 17) begin bad_cnt++; $display("FAIL b2b_first got=%0d want=17", doneEdges[0]); end
      for (int i = 1; i < doneEdges.size(); i++) begin
        total_cnt++; if (doneEdges[i] - doneEdges[i-1] !== 18) begin bad_cnt++; $display("FAIL b2b_gap got=%0d want=18", doneEdges[i] - doneEdges[i-1]); end
      end
    end
    total_cnt++; if (total !== expTot) begin bad_cnt++; $display("FAIL b2b_total got=%0d want=%0d", total, expTot); end
  endtask

  task automatic test_reset_mid_scan();
    for (int k = 0; k < 16; k++) ram[k] = 32'(k + 1);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    for (int e = 1; e < 8; e++) @(negedge clk);
    rst_n = 1'b0; #1;
    total_cnt++; if (busy !== 1'b0) begin bad_cnt++; $display("FAIL abort_busy got=%0b want=0", busy); end
    total_cnt++; if (done !== 1'b0) begin bad_cnt++; $display("FAIL abort_done got=%0b want=0", done); end
    total_cnt++; if (total !== 32'd0) begin bad_cnt++; $display("FAIL abort_total got=%h want=0", total); end
    for (int r = 0; r < 4; r++) begin
      rowSel = r[1:0]; #1;
      total_cnt++; if (rowSum !== 32'd0) begin bad_cnt++; $display("FAIL abort_row%0d got=%h want=0", r, rowSum); end
    end
    @(negedge clk); @(negedge clk) rst_n = 1'b1;
    test_basic("after_abort");
  endtask

  task automatic test_write_during_scan();
    int lat = -1;
    for (int k = 0; k < 16; k++) ram[k] = 32'(k + 1);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    for (int e = 1; e <= 60; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (e == 5) ram[15] = 32'd100;
      if (done && lat < 0) lat = e;
    end
    model();
    total_cnt++; if (lat !== 17) begin bad_cnt++; $display("FAIL wr_latency got=%0d want=17", lat); end
    rowSel = 2'd3; #1;
    total_cnt++; if (rowSum !== expRow[3]) begin bad_cnt++; $display("FAIL wr_row3 got=%0d want=%0d", rowSum, expRow[3]); end
    total_cnt++; if (total !== expTot) begin bad_cnt++; $display("FAIL wr_total got=%0d want=%0d", total, expTot); end
  endtask

  task automatic test_random();
    int lat;
    for (int it = 0; it < 6; it++) begin
      for (int k = 0; k < 16; k++)
        ram[k] = (it % 2 == 0) ? $urandom : ($urandom >> 6);
      model();
      run_scan(lat);
      total_cnt++; if (lat !== 17) begin bad_cnt++; $display("FAIL rnd%0d_latency got=%0d want=17", it, lat); end
      for (int r = 0; r < 4; r++) begin
        rowSel = r[1:0]; #1;
        total_cnt++; if (rowSum !== expRow[r]) begin bad_cnt++; $display("FAIL rnd%0d_row%0d got=%h want=%h", it, r, rowSum, expRow[r]); end
      end
      total_cnt++; if (total !== expTot) begin bad_cnt++; $display("FAIL rnd%0d_total got=%h want=%h", it, total, expTot); end
      total_cnt++; if (ovf !== expOvf) begin bad_cnt++; $display("FAIL rnd%0d_ovf got=%0b want=%0b", it, ovf, expOvf); end
    end
  endtask

  initial begin
    test_reset();
    test_basic("basic");
    test_saturate();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_scan();
    test_write_during_scan();
    test_random();
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end
endmodule
